lsu_split_ctrl: RTL and testbench

//  Sequential load/store controller between the MEM stage and a word-wide data bus.

---
 rtl/lsu_split_ctrl_if.sv | 37 +++
 rtl/lsu_split_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lsu_split_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_split_ctrl_if.sv
// Bundle of the MEM-stage request/response handshake and the word-wide data bus.
// The controller takes the slave view; the pipeline stage and bus fabric take the master view.
interface lsu_split_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3:0]        req_sl_type_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_wstrb_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic              mem_err_i;

    modport slave (
        input  req_valid_i, req_sl_type_i, req_addr_i, req_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_sl_type_i, req_addr_i, req_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_split_ctrl.sv
// Load/store controller: one access per request, split into at most two aligned bus beats,
// with lane alignment of store data and alignment plus extension of load data.
module lsu_split_ctrl #(
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    lsu_split_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t            state_reg;
    logic [3:0]        type_reg;
    logic [1:0]        off_reg;
    logic [ADDR_W-1:0] base_addr_reg;
    logic [7:0]        mask_reg;
    logic [63:0]       data_reg;
    logic [31:0]       lo_reg;

    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic [31:0]       resp_rdata_reg;
    logic              resp_err_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_wstrb_reg;
    logic [31:0]       mem_wdata_reg;

    // Request decode: byte mask and lane-shifted data spanning two words.
    logic [1:0]  in_size;
    logic [1:0]  in_off;
    logic [7:0]  size_mask;
    logic [7:0]  in_mask;
    logic [63:0] in_data;
    logic        in_misaligned;
    logic        in_bad_size;
    logic        in_store;

    assign in_size  = bus.req_sl_type_i[1:0];
    assign in_off   = bus.req_addr_i[1:0];
    assign in_store = bus.req_sl_type_i[3];

    always_comb begin
        size_mask = 8'h00;
        case (in_size)
            2'b01:   size_mask = 8'h01;
            2'b10:   size_mask = 8'h03;
            2'b11:   size_mask = 8'h0F;
            default: size_mask = 8'h00;
        endcase
    end

    assign in_mask       = size_mask << in_off;
    assign in_data       = {32'b0, bus.req_wdata_i} << {in_off, 3'b000};
    assign in_misaligned = ((in_size == 2'b10) && in_off[0]) ||
                           ((in_size == 2'b11) && (in_off != 2'b00));
    assign in_bad_size   = (in_size == 2'b00);

    // Load path: hi only contributes on the second beat of a split access.
    logic [23:0] ld_hi;
    logic [31:0] ld_lo;
    logic [31:0] ld_raw;
    logic [31:0] ld_ext;
    logic [31:0] ld_result;

    assign ld_hi = (state_reg == WAIT1) ? bus.mem_rdata_i[23:0] : 24'b0;
    assign ld_lo = (state_reg == WAIT1) ? lo_reg : bus.mem_rdata_i;

    always_comb begin
        ld_raw = ld_lo;
        case (off_reg)
            2'd1:    ld_raw = {ld_hi[7:0],  ld_lo[31:8]};
            2'd2:    ld_raw = {ld_hi[15:0], ld_lo[31:16]};
            2'd3:    ld_raw = {ld_hi[23:0], ld_lo[31:24]};
            default: ld_raw = ld_lo;
        endcase
    end

    always_comb begin
        ld_ext = ld_raw;
        case (type_reg[1:0])
            2'b01:   ld_ext = type_reg[2] ? {24'b0, ld_raw[7:0]}
                                          : {{24{ld_raw[7]}}, ld_raw[7:0]};
            2'b10:   ld_ext = type_reg[2] ? {16'b0, ld_raw[15:0]}
                                          : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    assign ld_result = type_reg[3] ? 32'b0 : ld_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            type_reg       <= 4'b0;
            off_reg        <= 2'b0;
            base_addr_reg  <= '0;
            mask_reg       <= 8'b0;
            data_reg       <= 64'b0;
            lo_reg         <= 32'b0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'b0;
            resp_err_reg   <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wstrb_reg  <= 4'b0;
            mem_wdata_reg  <= 32'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        type_reg      <= bus.req_sl_type_i;
                        off_reg       <= in_off;
                        base_addr_reg <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
                        mask_reg      <= in_mask;
                        data_reg      <= in_data;
                        req_ready_reg <= 1'b0;
                        if (in_bad_size || (!MISALIGN_EN && in_misaligned)) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'b0;
                        end else begin
                            state_reg     <= REQ0;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= in_store;
                            mem_addr_reg  <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_wstrb_reg <= in_store ? in_mask[3:0] : 4'b0;
                            mem_wdata_reg <= in_data[31:0];
                        end
                    end
                end
                REQ0: begin
                    if (bus.mem_gnt_i) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= WAIT0;
                    end
                end
                WAIT0: begin
                    if (bus.mem_rvalid_i) begin
                        lo_reg <= bus.mem_rdata_i;
                        if (bus.mem_err_i) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'b0;
                        end else if (mask_reg[7:4] != 4'b0) begin
                            state_reg     <= REQ1;
                            mem_req_reg   <= 1'b1;
                            mem_addr_reg  <= base_addr_reg + ADDR_W'(4);
                            mem_wstrb_reg <= type_reg[3] ? mask_reg[7:4] : 4'b0;
                            mem_wdata_reg <= data_reg[63:32];
                        end else begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b0;
                            resp_rdata_reg <= ld_result;
                        end
                    end
                end
                REQ1: begin
                    if (bus.mem_gnt_i) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (bus.mem_rvalid_i) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= bus.mem_err_i;
                        resp_rdata_reg <= bus.mem_err_i ? 32'b0 : ld_result;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = req_ready_reg;
    assign bus.resp_valid_o = resp_valid_reg;
    assign bus.resp_rdata_o = resp_rdata_reg;
    assign bus.resp_err_o   = resp_err_reg;
    assign bus.mem_req_o    = mem_req_reg;
    assign bus.mem_we_o     = mem_we_reg;
    assign bus.mem_addr_o   = mem_addr_reg;
    assign bus.mem_wstrb_o  = mem_wstrb_reg;
    assign bus.mem_wdata_o  = mem_wdata_reg;
endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Directed bench for lsu_split_ctrl: one instance splits misaligned accesses, one rejects them.
// A small bus model grants beats after a programmable delay and answers one cycle later.
module tb_lsu_split_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    bit          sel;            // 0: splitting instance, 1: rejecting instance
    logic        req_valid_t;
    logic [3:0]  req_type_t;
    logic [31:0] req_addr_t;
    logic [31:0] req_wdata_t;
    logic        gnt_t;
    logic        rvalid_t;
    logic        err_t;
    logic [31:0] rdata_t;

    lsu_split_ctrl_if #(.ADDR_W(32)) ma_if ();
    lsu_split_ctrl_if #(.ADDR_W(32)) nm_if ();

    assign ma_if.req_valid_i   = req_valid_t && !sel;
    assign ma_if.req_sl_type_i = req_type_t;
    assign ma_if.req_addr_i    = req_addr_t;
    assign ma_if.req_wdata_i   = req_wdata_t;
    assign ma_if.mem_gnt_i     = gnt_t && !sel;
    assign ma_if.mem_rvalid_i  = rvalid_t && !sel;
    assign ma_if.mem_rdata_i   = rdata_t;
    assign ma_if.mem_err_i     = err_t;

    assign nm_if.req_valid_i   = req_valid_t && sel;
    assign nm_if.req_sl_type_i = req_type_t;
    assign nm_if.req_addr_i    = req_addr_t;
    assign nm_if.req_wdata_i   = req_wdata_t;
    assign nm_if.mem_gnt_i     = gnt_t && sel;
    assign nm_if.mem_rvalid_i  = rvalid_t && sel;
    assign nm_if.mem_rdata_i   = rdata_t;
    assign nm_if.mem_err_i     = err_t;

    lsu_split_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b1)) dut_ma (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ma_if.slave)
    );

    lsu_split_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b0)) dut_nm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nm_if.slave)
    );

    wire        cur_ready = sel ? nm_if.req_ready_o  : ma_if.req_ready_o;
    wire        cur_rv    = sel ? nm_if.resp_valid_o : ma_if.resp_valid_o;
    wire [31:0] cur_rd    = sel ? nm_if.resp_rdata_o : ma_if.resp_rdata_o;
    wire        cur_re    = sel ? nm_if.resp_err_o   : ma_if.resp_err_o;
    wire        cur_req   = sel ? nm_if.mem_req_o    : ma_if.mem_req_o;
    wire        cur_we    = sel ? nm_if.mem_we_o     : ma_if.mem_we_o;
    wire [31:0] cur_addr  = sel ? nm_if.mem_addr_o   : ma_if.mem_addr_o;
    wire [3:0]  cur_strb  = sel ? nm_if.mem_wstrb_o  : ma_if.mem_wstrb_o;
    wire [31:0] cur_wdata = sel ? nm_if.mem_wdata_o  : ma_if.mem_wdata_o;

    // Bus model state and beat log.
    int          gnt_delay;
    int          wait_cnt;
    int          n_beats;
    int          unstable_cnt;
    bit          no_rsp;
    logic [31:0] rd_beat [2];
    logic        err_beat [2];
    logic [31:0] b_addr [4];
    logic [31:0] b_wdata [4];
    logic [3:0]  b_strb [4];
    logic        b_we [4];
    logic [68:0] snap;
    logic [68:0] gsnap;

    always @(negedge clk) begin
        rvalid_t = 1'b0;
        err_t    = 1'b0;
        if (gnt_t) begin
            if (n_beats < 4) begin
                {b_addr[n_beats], b_we[n_beats], b_strb[n_beats], b_wdata[n_beats]} = gsnap;
            end
            if (!no_rsp) begin
                rvalid_t = 1'b1;
                rdata_t  = rd_beat[(n_beats > 0) ? 1 : 0];
                err_t    = err_beat[(n_beats > 0) ? 1 : 0];
            end
            n_beats++;
            wait_cnt = 0;
            gnt_t    = 1'b0;
        end
        if (cur_req) begin
            if (wait_cnt == 0) snap = {cur_addr, cur_we, cur_strb, cur_wdata};
            else if ({cur_addr, cur_we, cur_strb, cur_wdata} !== snap) unstable_cnt++;
            if (wait_cnt >= gnt_delay) begin
                gnt_t = 1'b1;
                gsnap = {cur_addr, cur_we, cur_strb, cur_wdata};
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_access(input string tag, input bit nm, input logic [3:0] typ,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat);
        bit got;
        got   = 1'b0;
        rdata = 32'hX;
        err   = 1'bX;
        lat   = -1;
        @(negedge clk);
        sel          = nm;
        n_beats      = 0;
        wait_cnt     = 0;
        unstable_cnt = 0;
        check({tag, "_ready"}, cur_ready, 1);
        req_valid_t = 1'b1;
        req_type_t  = typ;
        req_addr_t  = addr;
        req_wdata_t = wdata;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid_t = 1'b0;
            if (cur_rv) begin
                got   = 1'b1;
                lat   = c;
                rdata = cur_rd;
                err   = cur_re;
                break;
            end
        end
        check({tag, "_resp_seen"}, got, 1);
        if (got) begin
            @(negedge clk);
            check({tag, "_pulse"}, cur_rv, 0);
            check({tag, "_hold"}, {cur_re, cur_rd}, {err, rdata});
        end
        $display("[TB] %s typ=%b addr=0x%08h beats=%0d rdata=0x%08h err=%0b lat=%0d",
                 tag, typ, addr, n_beats, rdata, err, lat);
    endtask

    logic [31:0] r;
    logic        e;
    int          l;
    int          pulses;
    bit          reached;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        sel          = 1'b0;
        req_valid_t  = 1'b0;
        req_type_t   = 4'b0;
        req_addr_t   = 32'b0;
        req_wdata_t  = 32'b0;
        gnt_t        = 1'b0;
        rvalid_t     = 1'b0;
        err_t        = 1'b0;
        rdata_t      = 32'b0;
        gnt_delay    = 0;
        wait_cnt     = 0;
        n_beats      = 0;
        unstable_cnt = 0;
        no_rsp       = 1'b0;
        rd_beat      = '{32'h0, 32'h0};
        err_beat     = '{1'b0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cur_ready, 1);
        check("rst_flags", {cur_rv, cur_re, cur_req, cur_we, cur_strb}, 0);
        check("rst_addr", cur_addr, 0);
        check("rst_wdata", cur_wdata, 0);
        check("rst_rdata", cur_rd, 0);
        rst_n = 1'b1;

        // Aligned word load
        rd_beat = '{32'hDEADBEEF, 32'h0};
        run_access("lw", 0, 4'b0011, 32'h100, 32'h0, r, e, l);
        check("lw_data", r, 32'hDEADBEEF);
        check("lw_err", e, 0);
        check("lw_lat", l, 3);
        check("lw_beats", n_beats, 1);
        check("lw_beat", {b_addr[0], b_we[0], b_strb[0]}, {32'h100, 1'b0, 4'b0000});

        // Byte loads from the top lane, signed and unsigned
        rd_beat = '{32'h80112233, 32'h0};
        run_access("lb", 0, 4'b0001, 32'h103, 32'h0, r, e, l);
        check("lb_data", r, 32'hFFFFFF80);
        check("lb_addr", b_addr[0], 32'h100);
        run_access("lbu", 0, 4'b0101, 32'h103, 32'h0, r, e, l);
        check("lbu_data", r, 32'h00000080);

        // Misaligned word store split over two beats
        run_access("sw_split", 0, 4'b1011, 32'h102, 32'hAABBCCDD, r, e, l);
        check("sw_beats", n_beats, 2);
        check("sw_b0", {b_addr[0], b_we[0], b_strb[0]}, {32'h100, 1'b1, 4'b1100});
        check("sw_b0_data", b_wdata[0], 32'hCCDD0000);
        check("sw_b1", {b_addr[1], b_we[1], b_strb[1]}, {32'h104, 1'b1, 4'b0011});
        check("sw_b1_data", b_wdata[1], 32'h0000AABB);
        check("sw_resp", {e, r}, {1'b0, 32'h0});
        check("sw_lat", l, 5);

        // Halfword load straddling a word boundary
        rd_beat = '{32'h12345678, 32'hABCDEF34};
        run_access("lh_split", 0, 4'b0010, 32'h0FF, 32'h0, r, e, l);
        check("lh_split_data", r, 32'h00003412);
        check("lh_split_addrs", {b_addr[0], b_addr[1]}, {32'h0FC, 32'h100});
        check("lh_split_strb", {b_strb[0], b_strb[1]}, 8'h00);

        // Misaligned word load on the splitting instance
        rd_beat = '{32'h44332211, 32'h88776655};
        run_access("lw_split", 0, 4'b0011, 32'h101, 32'h0, r, e, l);
        check("lw_split_data", r, 32'h55443322);
        check("lw_split_err", e, 0);

        // Rejecting instance: misaligned word and bad size
        run_access("lw_rej", 1, 4'b0011, 32'h101, 32'h0, r, e, l);
        check("lw_rej_resp", {e, r}, {1'b1, 32'h0});
        check("lw_rej_beats", n_beats, 0);
        check("lw_rej_lat", l, 1);
        run_access("sz0_nm", 1, 4'b0000, 32'h100, 32'h0, r, e, l);
        check("sz0_nm_resp", {e, r}, {1'b1, 32'h0});
        check("sz0_nm_beats", n_beats, 0);
        rd_beat = '{32'h55555555, 32'h0};
        run_access("sz0_ma", 0, 4'b0000, 32'h100, 32'h0, r, e, l);
        check("sz0_ma_resp", {e, r}, {1'b1, 32'h0});
        check("sz0_ma_beats", n_beats, 0);

        // Aligned halfword load on the rejecting instance still goes through
        rd_beat = '{32'hCAFE8001, 32'h0};
        run_access("lh_nm", 1, 4'b0010, 32'h102, 32'h0, r, e, l);
        check("lh_nm_data", r, 32'hFFFFCAFE);

        // Grant held low for five cycles
        gnt_delay = 5;
        run_access("sh_stall", 0, 4'b1010, 32'h202, 32'h12345678, r, e, l);
        check("sh_stall_beat", {b_addr[0], b_we[0], b_strb[0]}, {32'h200, 1'b1, 4'b1100});
        check("sh_stall_data", b_wdata[0], 32'h56780000);
        check("sh_stall_lat", l, 8);
        check("sh_stall_stable", unstable_cnt, 0);
        gnt_delay = 0;

        // Halfword at odd offset within one word
        rd_beat = '{32'h00F0F000, 32'h0};
        run_access("lhu_off1", 0, 4'b0110, 32'h201, 32'h0, r, e, l);
        check("lhu_off1_data", r, 32'h0000F0F0);
        check("lhu_off1_beats", n_beats, 1);
        run_access("lh_off1", 0, 4'b0010, 32'h201, 32'h0, r, e, l);
        check("lh_off1_data", r, 32'hFFFFF0F0);

        // Byte store to top lane
        run_access("sb", 0, 4'b1001, 32'h003, 32'h000000EE, r, e, l);
        check("sb_beat", {b_addr[0], b_we[0], b_strb[0]}, {32'h0, 1'b1, 4'b1000});
        check("sb_data", b_wdata[0], 32'hEE000000);

        // Second beat address wraps past the top of the address space
        rd_beat = '{32'h11223344, 32'h55667788};
        run_access("lw_wrap", 0, 4'b0011, 32'hFFFFFFFE, 32'h0, r, e, l);
        check("lw_wrap_addrs", {b_addr[0], b_addr[1]}, {32'hFFFFFFFC, 32'h0});
        check("lw_wrap_data", r, 32'h77881122);

        // Bus error on the first beat of a split: no second beat
        err_beat = '{1'b1, 1'b0};
        run_access("err_b0", 0, 4'b0011, 32'h106, 32'h0, r, e, l);
        check("err_b0_beats", n_beats, 1);
        check("err_b0_resp", {e, r}, {1'b1, 32'h0});
        err_beat = '{1'b0, 1'b1};
        run_access("err_b1", 0, 4'b0011, 32'h106, 32'h0, r, e, l);
        check("err_b1_beats", n_beats, 2);
        check("err_b1_resp", {e, r}, {1'b1, 32'h0});
        err_beat = '{1'b0, 1'b0};

        // Reset while waiting for the first beat's completion
        no_rsp  = 1'b1;
        reached = 1'b0;
        @(negedge clk);
        sel         = 1'b0;
        n_beats     = 0;
        wait_cnt    = 0;
        req_valid_t = 1'b1;
        req_type_t  = 4'b0011;
        req_addr_t  = 32'h300;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid_t = 1'b0;
            if (n_beats == 1) begin
                reached = 1'b1;
                break;
            end
        end
        check("rst_mid_reached", reached, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready", cur_ready, 1);
        check("rst_mid_flags", {cur_rv, cur_re, cur_req, cur_we, cur_strb}, 0);
        check("rst_mid_addr", cur_addr, 0);
        check("rst_mid_data", {cur_rd, cur_wdata}, 64'h0);
        rst_n  = 1'b1;
        no_rsp = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cur_rv || cur_req) pulses++;
        end
        check("rst_mid_quiet", pulses, 0);

        rd_beat = '{32'h0BADF00D, 32'h0};
        run_access("lw_after_rst", 0, 4'b0011, 32'h300, 32'h0, r, e, l);
        check("lw_after_rst_data", r, 32'h0BADF00D);
        check("lw_after_rst_lat", l, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
